// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the reset sequencer.
package clk_rst_pkg;

  typedef enum logic [1:0] {RESET, HOLD, STAGE, RUN} seq_state_e;

  // Width needed to count up to the largest of the three sequencing intervals.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned stage_gap,
                                            input int unsigned sw_rst_cycles);
    int unsigned m;
    m = hold_cycles;
    if (stage_gap > m) m = stage_gap;
    if (sw_rst_cycles > m) m = sw_rst_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_rst_ch.sv
// One reset domain: release/software-reset register plus clock-enable divider.
module clk_rst_ch
  import clk_rst_pkg::*;
#(
  parameter int unsigned SwRstCycles = 4,
  parameter int unsigned DivW        = 8,
  parameter int unsigned CntW        = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rel_i,
  input  logic            run_i,
  input  logic            sw_rst_i,
  input  logic [DivW-1:0] div_i,
  output logic            rstn_o,
  output logic            rstn_next_o,
  output logic            clk_en_o
);

  logic            rstn_q, rstn_d;
  logic [CntW-1:0] sw_cnt_q, sw_cnt_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            div_hit;

  // Release, software reset and divider next-state.
  always_comb begin
    rstn_d    = rstn_q;
    sw_cnt_d  = sw_cnt_q;
    div_cnt_d = '0;
    div_hit   = (div_cnt_q >= div_i);
    if (rel_i) rstn_d = 1'b1;
    // In RUN every domain is released, so a low rstn here means a software reset is running.
    if (run_i) begin
      if (sw_rst_i) begin
        rstn_d   = 1'b0;
        sw_cnt_d = CntW'(SwRstCycles - 1);
      end else if (!rstn_q) begin
        if (sw_cnt_q == '0) rstn_d = 1'b1;
        else                sw_cnt_d = sw_cnt_q - CntW'(1);
      end
    end
    if (rstn_q && !div_hit) div_cnt_d = div_cnt_q + DivW'(1);
  end

  // Domain state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rstn_q    <= 1'b0;
      sw_cnt_q  <= '0;
      div_cnt_q <= '0;
    end else begin
      rstn_q    <= rstn_d;
      sw_cnt_q  <= sw_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign rstn_o      = rstn_q;
  assign rstn_next_o = rstn_d;
  assign clk_en_o    = rstn_q & div_hit;

endmodule

// File: rtl/clk_rst_seq.sv
// Staggered multi-domain reset sequencer with per-domain clock-enable dividers.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned STAGE_GAP     = 8,
  parameter int unsigned SW_RST_CYCLES = 4,
  parameter int unsigned DIV_W         = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    testmode_i,
  input  logic [NUM_CH-1:0]       sw_rst_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       rstn_o,
  output logic [NUM_CH-1:0]       clk_en_o,
  output logic                    done_o
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, STAGE_GAP, SW_RST_CYCLES);
  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  seq_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] rel;
  logic [NUM_CH-1:0] rstn_q;
  logic [NUM_CH-1:0] rstn_next;
  logic [NUM_CH-1:0] clk_en;

  // Sequencer next-state, release strobes and done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel     = '0;
    case (state_q)
      RESET: begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
      end
      HOLD: begin
        if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
          rel[0]  = 1'b1;
          cnt_d   = '0;
          idx_d   = IdxW'(1);
          state_d = (NUM_CH == 1) ? RUN : STAGE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STAGE: begin
        if (cnt_q == CntW'(STAGE_GAP - 1)) begin
          rel[idx_q] = 1'b1;
          cnt_d      = '0;
          if (idx_q == IdxW'(NUM_CH - 1)) state_d = RUN;
          else                            idx_d   = idx_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RUN: ;
      default: state_d = RESET;
    endcase
    if (rst_i) begin
      state_d = RESET;
      cnt_d   = '0;
      idx_d   = '0;
      rel     = '0;
    end
    // Look at next-state so done drops on the same edge a software reset starts.
    done_d = (state_d == RUN) & (&rstn_next);
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_rst_ch #(
      .SwRstCycles(SW_RST_CYCLES),
      .DivW       (DIV_W),
      .CntW       (CntW)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rel_i      (rel[k]),
      .run_i      (state_q == RUN),
      .sw_rst_i   (sw_rst_i[k]),
      .div_i      (div_i[k*DIV_W +: DIV_W]),
      .rstn_o     (rstn_q[k]),
      .rstn_next_o(rstn_next[k]),
      .clk_en_o   (clk_en[k])
    );
  end

  // Test bypass is purely combinational; the sequencer keeps running underneath.
  assign rstn_o   = testmode_i ? {NUM_CH{~rst_i}} : rstn_q;
  assign clk_en_o = testmode_i ? {NUM_CH{1'b1}} : clk_en;
  assign done_o   = testmode_i ? ~rst_i : done_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: timeline model plus directed scenarios with literal checks.
module tb_clk_rst_seq;

  localparam int NCh  = 4;
  localparam int Hold = 16;
  localparam int Gap  = 8;
  localparam int SwR  = 4;
  localparam int DivW = 8;
  localparam int TLast = Hold + (NCh - 1) * Gap;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  testmode_i = 1'b0;
  logic [NCh-1:0]        sw_rst_i = '0;
  logic [NCh*DivW-1:0]   div_i = {8'd0, 8'd1, 8'd3, 8'd7};
  logic [NCh-1:0]        rstn_o;
  logic [NCh-1:0]        clk_en_o;
  logic                  done_o;

  int n_checks = 0;
  int n_err    = 0;

  clk_rst_seq dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .testmode_i(testmode_i),
    .sw_rst_i  (sw_rst_i),
    .div_i     (div_i),
    .rstn_o    (rstn_o),
    .clk_en_o  (clk_en_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: edge index, edge of first rst_i=0, software-reset end edges.
  int  ecnt = 0;
  int  e0 = 0;
  bit  active = 0;
  bit  started = 0;
  int  sw_end [NCh];

  initial for (int k = 0; k < NCh; k++) sw_end[k] = 0;

  always @(posedge clk_i) begin
    ecnt++;
    if (rst_i) begin
      active = 0;
      for (int k = 0; k < NCh; k++) sw_end[k] = 0;
    end else if (!active) begin
      active = 1;
      e0 = ecnt;
    end else if ((ecnt - 1 - e0) >= TLast) begin
      for (int k = 0; k < NCh; k++) if (sw_rst_i[k]) sw_end[k] = ecnt + SwR;
    end
    started = 1;
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk_i) begin
    if (started) begin
      logic [NCh-1:0] exp_rstn, exp_en;
      logic           exp_done;
      int t, base, lr, dv;
      t = ecnt - e0;
      exp_done = active && (t >= TLast);
      for (int k = 0; k < NCh; k++) begin
        base = e0 + Hold + k * Gap;
        exp_rstn[k] = active && (t >= Hold + k * Gap) && (ecnt >= sw_end[k]);
        lr = (sw_end[k] > base) ? sw_end[k] : base;
        dv = int'(div_i[k*DivW +: DivW]);
        exp_en[k] = exp_rstn[k] && (((ecnt - lr) % (dv + 1)) == dv);
        if (ecnt < sw_end[k]) exp_done = 1'b0;
      end
      if (testmode_i) begin
        exp_rstn = {NCh{~rst_i}};
        exp_en   = '1;
        exp_done = ~rst_i;
      end
      check("model_rstn", 32'(rstn_o), 32'(exp_rstn));
      check("model_clk_en", 32'(clk_en_o), 32'(exp_en));
      check("model_done", 32'(done_o), 32'(exp_done));
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_sw(input logic [NCh-1:0] v);
    sw_rst_i = v;
    wait_edges(1);
    sw_rst_i = '0;
  endtask

  initial begin
    // Scenario 1: schedule after reset, with sw_rst_i ignored in HOLD and STAGE.
    wait_edges(5);
    rst_i = 1'b0;
    wait_edges(1);
    check("e0_rstn", 32'(rstn_o), 32'h0);
    pulse_sw(4'hF);
    wait_edges(14);
    check("t15_rstn", 32'(rstn_o), 32'h0);
    wait_edges(1);
    check("t16_rstn", 32'(rstn_o), 32'h1);
    check("t16_clk_en", 32'(clk_en_o), 32'h0);
    pulse_sw(4'hF);
    wait_edges(7);
    check("t24_rstn", 32'(rstn_o), 32'h3);
    wait_edges(15);
    check("t39_rstn", 32'(rstn_o), 32'h7);
    check("t39_done", 32'(done_o), 32'h0);
    wait_edges(1);
    check("t40_rstn", 32'(rstn_o), 32'hF);
    check("t40_done", 32'(done_o), 32'h1);
    check("t40_clk_en", 32'(clk_en_o), 32'h8);

    // Scenario 2: divider pulse trains, checked by the model.
    wait_edges(20);

    // Scenario 3: single software reset on channel 1.
    pulse_sw(4'b0010);
    check("sw_e_rstn", 32'(rstn_o), 32'hD);
    check("sw_e_done", 32'(done_o), 32'h0);
    wait_edges(3);
    check("sw_e3_rstn", 32'(rstn_o), 32'hD);
    wait_edges(1);
    check("sw_e4_rstn", 32'(rstn_o), 32'hF);
    check("sw_e4_done", 32'(done_o), 32'h1);
    wait_edges(10);

    // Scenario 4: retrigger restarts the count; then a multi-channel request.
    pulse_sw(4'b0010);
    wait_edges(1);
    pulse_sw(4'b0010);
    wait_edges(3);
    check("retrig_e5_rstn", 32'(rstn_o), 32'hD);
    wait_edges(1);
    check("retrig_e6_rstn", 32'(rstn_o), 32'hF);
    pulse_sw(4'b1001);
    check("multi_rstn", 32'(rstn_o), 32'h6);
    wait_edges(12);

    // Scenario 5: reset mid-sequence, then full replay.
    rst_i = 1'b1;
    wait_edges(3);
    rst_i = 1'b0;
    wait_edges(1);
    wait_edges(27);
    check("mid_t27_rstn", 32'(rstn_o), 32'h3);
    rst_i = 1'b1;
    wait_edges(1);
    check("mid_rst_rstn", 32'(rstn_o), 32'h0);
    check("mid_rst_done", 32'(done_o), 32'h0);
    wait_edges(2);
    rst_i = 1'b0;
    wait_edges(1);
    wait_edges(39);
    check("replay_t39_rstn", 32'(rstn_o), 32'h7);
    wait_edges(1);
    check("replay_t40_done", 32'(done_o), 32'h1);

    // Scenario 6: test bypass with rst_i toggling, then leave bypass in RUN.
    testmode_i = 1'b1;
    rst_i = 1'b1;
    #1;
    check("tm_rst1_rstn", 32'(rstn_o), 32'h0);
    check("tm_rst1_clk_en", 32'(clk_en_o), 32'hF);
    check("tm_rst1_done", 32'(done_o), 32'h0);
    wait_edges(1);
    rst_i = 1'b0;
    #1;
    check("tm_rst0_rstn", 32'(rstn_o), 32'hF);
    check("tm_rst0_done", 32'(done_o), 32'h1);
    wait_edges(1);
    rst_i = 1'b1;
    wait_edges(2);
    rst_i = 1'b0;
    wait_edges(45);
    testmode_i = 1'b0;
    #1;
    check("tm_exit_done", 32'(done_o), 32'h1);
    check("tm_exit_rstn", 32'(rstn_o), 32'hF);
    wait_edges(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
